regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the write data.
REQ-002 SHALL have parameter ADDR_W, default 5: width of the register address.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as follows.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 req0_valid_i  input  1  EX-stage (ALU) write request valid.
REQ-007 req0_addr_i  input  ADDR_W  EX-stage destination register.
REQ-008 req0_data_i  input  DATA_W  EX-stage write data.
REQ-009 req0_ready_o  output  1  EX-stage request accepted this cycle.
REQ-010 req1_valid_i, req1_addr_i, req1_data_i, req1_ready_o  same widths and directions  MEM-stage (load) requester.
REQ-011 rd_enable_o  output  1  register-file write enable.
REQ-012 rd_addr_o  output  ADDR_W  register-file write address.
REQ-013 rd_data_o  output  DATA_W  register-file write data.
REQ-014 busy_o  output  1  high when both requesters are valid in the same cycle (contention indicator).

Function
REQ-015 Handshake: a transfer on requester N occurs in a cycle where reqN_valid_i and reqN_ready_o are both high.
REQ-016 A requester, once valid, SHALL hold valid, addr and data stable until accepted; the arbiter need not check this.
REQ-017 reqN_ready_o SHALL be combinational from the current valids and the arbitration state; at most one ready is high per cycle.
REQ-018 Only one valid requester: that requester SHALL be granted in the same cycle.
REQ-019 Both valid, same address: req1 (older instruction) SHALL be granted, regardless of arbitration state, to preserve program order.
REQ-020 Both valid, different addresses: the winner SHALL follow the arbitration policy in REQ-030/REQ-031.
REQ-021 Latency: an accepted request SHALL appear on rd_*_o exactly one cycle after acceptance, with rd_enable_o high for exactly one cycle.
REQ-022 Accepted request with address 0: SHALL be consumed (ready high), and rd_enable_o SHALL stay low the next cycle.
REQ-023 No transfer: rd_enable_o SHALL be low the next cycle; rd_addr_o and rd_data_o SHALL hold their last values.
REQ-024 busy_o SHALL equal req0_valid_i AND req1_valid_i (combinational).
REQ-025 Arbitration state: a 1-bit last-grant pointer lp; updated only on a transfer, to the index of the granted requester.
REQ-026 No deadlock: a continuously valid requester SHALL be granted within 2 cycles under REQ-030.

Reset
REQ-027 While rst is low: rd_enable_o=0, rd_addr_o=0, rd_data_o=0, lp=1 (so req0 wins the first contended cycle), and both ready outputs low.
REQ-028 Reset assertion mid-transfer SHALL cancel any pending output write immediately (asynchronously); a request presented in the cycle reset is asserted is not accepted.
REQ-029 The first transfer is possible in the first rising edge after rst deasserts.

Configuration
REQ-030 With macro WB_ARB_RR_EN defined: contended, different-address cycles SHALL be granted round-robin, to the requester not equal to lp.
REQ-031 Without WB_ARB_RR_EN: contended, different-address cycles SHALL be granted to req1 under fixed priority; lp SHALL still be tracked but ignored; REQ-026 does not apply.

Verification
REQ-032 Reset, then req0 valid only with addr=3, data=0x11 -> req0_ready_o=1 same cycle; next cycle rd_enable_o=1, rd_addr_o=3, rd_data_o=0x11.
REQ-033 Both valid with addr=5 (req0 data 0xA, req1 data 0xB) -> cycle 1 grants req1; cycle 2 grants req0; rd writes 0xB then 0xA to x5 on consecutive cycles.
REQ-034 WB_ARB_RR_EN defined, both valid continuously with addr0=1, addr1=2 and new data each transfer -> grants alternate req0, req1, req0, ...; busy_o=1 throughout.
REQ-035 WB_ARB_RR_EN undefined, same stimulus as REQ-034 -> req1 granted every cycle and req0_ready_o stays 0.
REQ-036 req1 valid with addr=0, data=0xFFFF -> req1_ready_o=1; next cycle rd_enable_o=0.
REQ-037 Transfer accepted, then rst pulled low before the next edge -> rd_enable_o drops to 0 immediately, and no write occurs.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: bundle of the two write-back requesters and the register-file
//   write port served by regfile_wb_arbiter.
// Handshake: requester N transfers in a cycle where reqN_valid_i and
//   reqN_ready_o are both high. Once valid, a requester holds valid, addr
//   and data stable until it is accepted. Ready is combinational from the
//   valids and may be observed in the same cycle.
// Signals:
//   req0_*        EX-stage (ALU) requester: valid/addr/data in, ready out
//   req1_*        MEM-stage (load) requester: valid/addr/data in, ready out
//   rd_enable_o   register-file write enable (one cycle per accepted write)
//   rd_addr_o     register-file write address
//   rd_data_o     register-file write data
//   busy_o        both requesters valid in the same cycle
// Modports: slave = arbiter side, master = requester / register-file side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_data_i;
  logic              req0_ready_o;
  logic              req1_valid_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_data_i;
  logic              req1_ready_o;
  logic              rd_enable_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              busy_o;

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    output req0_ready_o, req1_ready_o,
    output rd_enable_o, rd_addr_o, rd_data_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i,
    output req1_valid_i, req1_addr_i, req1_data_i,
    input  req0_ready_o, req1_ready_o,
    input  rd_enable_o, rd_addr_o, rd_data_o, busy_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates two write-back requesters (EX = req0, MEM = req1)
//   onto the single register-file write port. The accepted request appears
//   on rd_* one cycle after acceptance; writes to x0 are consumed but never
//   raise rd_enable_o.
// Ports:
//   clk     sole clock, rising edge
//   rst     asynchronous reset, active low
//   bus     regfile_wb_arbiter_if.slave (requesters + write port + busy)
//   dbg_lp  last-grant pointer (arbitration state), for observation
// Configuration:
//   WB_ARB_RR_EN  defined: contended different-address cycles are granted
//                 round-robin (to the requester other than the last grant).
//                 undefined: such cycles go to req1 (fixed priority).
//   Same-address contention always goes to req1, the older instruction,
//   so the younger write lands last and program order is preserved.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus,
  output logic                dbg_lp
);

  logic lp;       // index of the last granted requester
  logic pick1;    // arbitration choice when req1 is a candidate
  logic both;
  logic same_addr;

  assign both      = bus.req0_valid_i & bus.req1_valid_i;
  assign same_addr = (bus.req0_addr_i == bus.req1_addr_i);
  assign bus.busy_o = both;
  assign dbg_lp    = lp;

  always_comb begin
    pick1 = 1'b0;
    if (both) begin
      if (same_addr) begin
        pick1 = 1'b1;
      end else begin
`ifdef WB_ARB_RR_EN
        pick1 = ~lp;
`else
        pick1 = 1'b1;
`endif
      end
    end else begin
      pick1 = bus.req1_valid_i;
    end
  end

  // rst gates the readies so nothing is accepted while reset is held.
  assign bus.req0_ready_o = rst & bus.req0_valid_i & ~pick1;
  assign bus.req1_ready_o = rst & bus.req1_valid_i & pick1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rd_enable_o <= 1'b0;
      bus.rd_addr_o   <= '0;
      bus.rd_data_o   <= '0;
      lp              <= 1'b1;
    end else begin
      bus.rd_enable_o <= 1'b0;
      if (bus.req1_ready_o) begin
        lp <= 1'b1;
        // x0 writes are consumed silently; rd_addr/rd_data keep the last
        // real write so they only ever change alongside rd_enable_o.
        if (bus.req1_addr_i != '0) begin
          bus.rd_enable_o <= 1'b1;
          bus.rd_addr_o   <= bus.req1_addr_i;
          bus.rd_data_o   <= bus.req1_data_i;
        end
      end else if (bus.req0_ready_o) begin
        lp <= 1'b0;
        if (bus.req0_addr_i != '0) begin
          bus.rd_enable_o <= 1'b1;
          bus.rd_addr_o   <= bus.req0_addr_i;
          bus.rd_data_o   <= bus.req0_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change 1 time unit
// after a rising edge; combinational readies are sampled 1 unit later and
// registered outputs right after each edge + 1.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;
  logic dbg_lp;
  int   total;
  int   bad;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .dbg_lp (dbg_lp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.req0_valid_i = v;
    bus.req0_addr_i  = a;
    bus.req0_data_i  = d;
  endtask

  task automatic drive1(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.req1_valid_i = v;
    bus.req1_addr_i  = a;
    bus.req1_data_i  = d;
  endtask

  task automatic check_rd(input string tag, input logic en,
                          input logic [4:0] a, input logic [31:0] d);
    check({tag, "_en"},   {31'd0, bus.rd_enable_o}, {31'd0, en});
    check({tag, "_addr"}, {27'd0, bus.rd_addr_o},   {27'd0, a});
    check({tag, "_data"}, bus.rd_data_o,            d);
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1,
                           input logic busy);
    check({tag, "_rdy0"}, {31'd0, bus.req0_ready_o}, {31'd0, r0});
    check({tag, "_rdy1"}, {31'd0, bus.req1_ready_o}, {31'd0, r1});
    check({tag, "_busy"}, {31'd0, bus.busy_o},       {31'd0, busy});
  endtask

  initial begin
    logic [31:0] d0, d1;
    logic        exp_win;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive0(1'b1, 5'd4, 32'h44);
    drive1(1'b1, 5'd6, 32'h66);

    // reset state, with requests presented that must not be accepted
    cyc();
    cyc();
    #1;
    check_rd("rst", 1'b0, 5'd0, 32'h0);
    check_rdy("rst", 1'b0, 1'b0, 1'b1);
    check("rst_lp", {31'd0, dbg_lp}, 32'd1);
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // single req0, addr 3 data 0x11
    cyc();
    drive0(1'b1, 5'd3, 32'h11);
    #1;
    check_rdy("single0", 1'b1, 1'b0, 1'b0);
    cyc();
    drive0(1'b0, 5'd0, 32'h0);
    check_rd("single0_wb", 1'b1, 5'd3, 32'h11);
    check("single0_lp", {31'd0, dbg_lp}, 32'd0);
    cyc();
    check_rd("idle_hold", 1'b0, 5'd3, 32'h11);

    // same-address contention: req1 first, then req0
    drive0(1'b1, 5'd5, 32'hA);
    drive1(1'b1, 5'd5, 32'hB);
    #1;
    check_rdy("same_c1", 1'b0, 1'b1, 1'b1);
    cyc();
    drive1(1'b0, 5'd0, 32'h0);
    check_rd("same_wb1", 1'b1, 5'd5, 32'hB);
    #1;
    check_rdy("same_c2", 1'b1, 1'b0, 1'b0);
    cyc();
    drive0(1'b0, 5'd0, 32'h0);
    check_rd("same_wb2", 1'b1, 5'd5, 32'hA);

    // req1 to x0 is consumed, no write
    drive1(1'b1, 5'd0, 32'hFFFF);
    #1;
    check_rdy("x0", 1'b0, 1'b1, 1'b0);
    cyc();
    drive1(1'b0, 5'd0, 32'h0);
    check("x0_en", {31'd0, bus.rd_enable_o}, 32'd0);
    check("x0_lp", {31'd0, dbg_lp}, 32'd1);

    // continuous different-address contention, lp = 1 at start
    d0 = 32'h100;
    d1 = 32'h200;
    for (int i = 0; i < 6; i++) begin
      drive0(1'b1, 5'd1, d0);
      drive1(1'b1, 5'd2, d1);
      #1;
`ifdef WB_ARB_RR_EN
      exp_win = (i % 2 == 1);
`else
      exp_win = 1'b1;
`endif
      check_rdy($sformatf("cont%0d", i), ~exp_win, exp_win, 1'b1);
      cyc();
      if (exp_win) begin
        check_rd($sformatf("cont%0d_wb", i), 1'b1, 5'd2, d1);
        d1 = d1 + 32'd1;
      end else begin
        check_rd($sformatf("cont%0d_wb", i), 1'b1, 5'd1, d0);
        d0 = d0 + 32'd1;
      end
    end
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);
    cyc();

    // accepted transfer, then reset before the next edge
    drive0(1'b1, 5'd7, 32'h77);
    #1;
    check_rdy("prerst", 1'b1, 1'b0, 1'b0);
    cyc();
    drive0(1'b0, 5'd0, 32'h0);
    check("prerst_en", {31'd0, bus.rd_enable_o}, 32'd1);
    drive1(1'b1, 5'd8, 32'h88);
    rst = 1'b0;
    #1;
    check_rd("midrst", 1'b0, 5'd0, 32'h0);
    check("midrst_rdy1", {31'd0, bus.req1_ready_o}, 32'd0);
    check("midrst_lp", {31'd0, dbg_lp}, 32'd1);
    cyc();
    check("midrst_en2", {31'd0, bus.rd_enable_o}, 32'd0);
    drive1(1'b0, 5'd0, 32'h0);

    // first edge after reset release accepts a transfer
    @(negedge clk);
    rst = 1'b1;
    drive0(1'b1, 5'd9, 32'h99);
    #1;
    check_rdy("postrst", 1'b1, 1'b0, 1'b0);
    cyc();
    drive0(1'b0, 5'd0, 32'h0);
    check_rd("postrst_wb", 1'b1, 5'd9, 32'h99);
    cyc();
    check("postrst_idle", {31'd0, bus.rd_enable_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
